// File: rtl/packet_buffer_pkg.sv
// Width-derivation helpers and legal data widths shared by the packet ring buffer,
// its slot memories and its bus interface.
package packet_buffer_pkg;

    localparam int byte_bits_lp = 8;

    typedef enum int {
        data_width_32  = 32,
        data_width_64  = 64,
        data_width_128 = 128
    } data_width_e;

    function automatic bit is_legal_data_width_f(input int width);
        return (width == int'(data_width_32)) || (width == int'(data_width_64)) ||
               (width == int'(data_width_128));
    endfunction

    function automatic int addr_width_f(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

    function automatic int size_width_f(input int els);
        return $clog2(els + 1);
    endfunction

    function automatic int lsb_width_f(input int data_width);
        return $clog2(data_width / byte_bits_lp);
    endfunction

    function automatic int word_addr_width_f(input int els, input int data_width);
        int width;
        width = addr_width_f(els) - lsb_width_f(data_width);
        return (width > 0) ? width : 1;
    endfunction

    function automatic int ptr_width_f(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    function automatic int occ_width_f(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/packet_ring_buffer_if.sv
// Producer/consumer bus of the packet ring buffer; the buffer sits on the slave side.
interface packet_ring_buffer_if #(
    parameter int slot_p       = 4,
    parameter int data_width_p = 64,
    parameter int els_p        = 2048
) ();
    import packet_buffer_pkg::*;

    localparam int aw_lp  = addr_width_f(els_p);
    localparam int sw_lp  = size_width_f(els_p);
    localparam int ow_lp  = occ_width_f(slot_p);
    localparam int bytes_lp = data_width_p / byte_bits_lp;

    logic                    packet_req_o;
    logic                    packet_send_i;
    logic                    packet_abort_i;
    logic                    packet_wsize_valid_i;
    logic [sw_lp-1:0]        packet_wsize_i;
    logic                    packet_wvalid_i;
    logic [aw_lp-1:0]        packet_waddr_i;
    logic [data_width_p-1:0] packet_wdata_i;
    logic [bytes_lp-1:0]     packet_wmask_i;
    logic                    packet_avail_o;
    logic                    packet_ack_i;
    logic                    packet_rvalid_i;
    logic [aw_lp-1:0]        packet_raddr_i;
    logic [data_width_p-1:0] packet_rdata_o;
    logic [sw_lp-1:0]        packet_rsize_o;
    logic [ow_lp-1:0]        occupancy_o;
    logic                    err_o;

    modport master (
        input  packet_req_o, packet_avail_o, packet_rdata_o, packet_rsize_o, occupancy_o, err_o,
        output packet_send_i, packet_abort_i, packet_wsize_valid_i, packet_wsize_i,
               packet_wvalid_i, packet_waddr_i, packet_wdata_i, packet_wmask_i,
               packet_ack_i, packet_rvalid_i, packet_raddr_i
    );

    modport slave (
        output packet_req_o, packet_avail_o, packet_rdata_o, packet_rsize_o, occupancy_o, err_o,
        input  packet_send_i, packet_abort_i, packet_wsize_valid_i, packet_wsize_i,
               packet_wvalid_i, packet_waddr_i, packet_wdata_i, packet_wmask_i,
               packet_ack_i, packet_rvalid_i, packet_raddr_i
    );

endinterface

// File: rtl/packet_slot_mem.sv
// One packet slot: single-port byte-masked synchronous RAM plus the slot's length register.
module packet_slot_mem
    import packet_buffer_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int els_p        = 2048,
    parameter int word_aw_p    = word_addr_width_f(els_p, data_width_p),
    parameter int size_w_p     = size_width_f(els_p)
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_we,
    input  logic                               i_re,
    input  logic [word_aw_p-1:0]               i_addr,
    input  logic [data_width_p-1:0]            i_wdata,
    input  logic [data_width_p/byte_bits_lp-1:0] i_wmask,
    output logic [data_width_p-1:0]            o_rdata,
    input  logic                               i_size_clr,
    input  logic                               i_size_we,
    input  logic [size_w_p-1:0]                i_size,
    output logic [size_w_p-1:0]                o_size
);

    localparam int bytes_lp = data_width_p / byte_bits_lp;
    localparam int depth_lp = els_p / bytes_lp;

    logic [data_width_p-1:0] r_mem [depth_lp];
    logic [data_width_p-1:0] r_rdata;
    logic [size_w_p-1:0]     r_size;
    logic                    w_in_range;

    assign w_in_range = (32'(i_addr) < 32'(depth_lp));

    // NOTE: the RAM array and its read register get no reset so they map onto block RAM;
    // only the length register, which gates what is visible, is reset.
    always_ff @(posedge i_clk) begin
        if (i_we && w_in_range) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_addr][b*byte_bits_lp +: byte_bits_lp] <= i_wdata[b*byte_bits_lp +: byte_bits_lp];
                end
            end
        end
        if (i_re && w_in_range) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_size <= '0;
        end else if (i_size_clr) begin
            r_size <= '0;
        end else if (i_size_we) begin
            r_size <= i_size;
        end
    end

    assign o_rdata = r_rdata;
    assign o_size  = r_size;

endmodule

// File: rtl/packet_ring_buffer.sv
// Ring of packet slots: the producer fills the slot at wptr and commits it, the consumer
// reads the slot at rptr and frees it. The two slots are never the same while both are usable.
module packet_ring_buffer #(
    parameter int slot_p       = 4,
    parameter int data_width_p = 64,
    parameter int els_p        = 2048
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    packet_ring_buffer_if.slave  bus
);
    import packet_buffer_pkg::*;

    localparam int aw_lp  = addr_width_f(els_p);
    localparam int sw_lp  = size_width_f(els_p);
    localparam int lsb_lp = lsb_width_f(data_width_p);
    localparam int waw_lp = word_addr_width_f(els_p, data_width_p);
    localparam int pw_lp  = ptr_width_f(slot_p);
    localparam int ow_lp  = occ_width_f(slot_p);

    logic [pw_lp-1:0]        r_wptr;
    logic [pw_lp-1:0]        r_rptr;
    logic [pw_lp-1:0]        r_rd_slot;
    logic [ow_lp-1:0]        r_occ;
    logic                    r_err;
    logic                    r_rd_pending;
    logic [data_width_p-1:0] r_rdata;

    logic w_req, w_avail, w_commit, w_abort, w_deq;
    logic w_waligned, w_raligned, w_wr_en, w_rd_en;
    logic w_size_legal, w_size_we, w_err_next;
    logic [waw_lp-1:0]       w_wword;
    logic [waw_lp-1:0]       w_rword;
    logic [data_width_p-1:0] w_slot_rdata [slot_p];
    logic [sw_lp-1:0]        w_slot_size  [slot_p];

    function automatic logic [pw_lp-1:0] ptr_inc_f(input logic [pw_lp-1:0] ptr);
        return (ptr == pw_lp'(slot_p - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_req    = (r_occ != ow_lp'(slot_p));
    assign w_avail  = (r_occ != '0);
    assign w_abort  = bus.packet_abort_i & w_req;
    assign w_commit = bus.packet_send_i & w_req & ~bus.packet_abort_i;
    assign w_deq    = bus.packet_ack_i & w_avail;

    assign w_waligned   = (bus.packet_waddr_i[lsb_lp-1:0] == '0);
    assign w_raligned   = (bus.packet_raddr_i[lsb_lp-1:0] == '0);
    assign w_wword      = bus.packet_waddr_i[aw_lp-1:lsb_lp];
    assign w_rword      = bus.packet_raddr_i[aw_lp-1:lsb_lp];
    assign w_wr_en      = bus.packet_wvalid_i & w_req & w_waligned;
    assign w_rd_en      = bus.packet_rvalid_i & w_avail & w_raligned;
    assign w_size_legal = (32'(bus.packet_wsize_i) <= 32'(els_p));
    assign w_size_we    = bus.packet_wsize_valid_i & w_req & w_size_legal & ~bus.packet_abort_i;

    assign w_err_next = (bus.packet_wvalid_i & w_req & ~w_waligned)
                      | (bus.packet_rvalid_i & w_avail & ~w_raligned)
                      | (bus.packet_wsize_valid_i & w_req & ~w_size_legal);

    // A slot is freed by clearing its length on dequeue, so a reused slot starts empty.
    for (genvar s = 0; s < slot_p; s++) begin : g_slot
        logic w_wsel;
        logic w_rsel;
        logic w_rd_here;

        assign w_wsel    = (r_wptr == pw_lp'(s));
        assign w_rsel    = (r_rptr == pw_lp'(s));
        assign w_rd_here = w_rd_en & w_rsel;

        packet_slot_mem #(
            .data_width_p (data_width_p),
            .els_p        (els_p)
        ) u_slot_mem (
            .i_clk      (clk_i),
            .i_reset    (reset_i),
            .i_we       (w_wr_en & w_wsel),
            .i_re       (w_rd_here),
            .i_addr     (w_rd_here ? w_rword : w_wword),
            .i_wdata    (bus.packet_wdata_i),
            .i_wmask    (bus.packet_wmask_i),
            .o_rdata    (w_slot_rdata[s]),
            .i_size_clr ((w_abort & w_wsel) | (w_deq & w_rsel)),
            .i_size_we  (w_size_we & w_wsel),
            .i_size     (bus.packet_wsize_i),
            .o_size     (w_slot_size[s])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_rd_slot    <= '0;
            r_occ        <= '0;
            r_err        <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_commit) r_wptr <= ptr_inc_f(r_wptr);
            if (w_deq)    r_rptr <= ptr_inc_f(r_rptr);
            if (w_commit && !w_deq) begin
                r_occ <= r_occ + 1'b1;
            end else if (!w_commit && w_deq) begin
                r_occ <= r_occ - 1'b1;
            end
            r_err        <= w_err_next;
            r_rd_pending <= w_rd_en;
            if (w_rd_en)      r_rd_slot <= r_rptr;
            if (r_rd_pending) r_rdata   <= w_slot_rdata[r_rd_slot];
        end
    end

    // Fresh RAM data for one cycle after a read, then the captured copy until the next read.
    assign bus.packet_rdata_o = r_rd_pending ? w_slot_rdata[r_rd_slot] : r_rdata;
    assign bus.packet_rsize_o = w_avail ? w_slot_size[r_rptr] : '0;
    assign bus.packet_req_o   = w_req;
    assign bus.packet_avail_o = w_avail;
    assign bus.occupancy_o    = r_occ;
    assign bus.err_o          = r_err;

endmodule
